// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Bundles the control sequencer's datapath/memory handshake signals.
//   master : the sequencer (drives strobes, consumes halt/mem_ready/opcode)
//   slave  : the datapath / memory side
// Signals
//   halt, mem_ready, opcode[6:0]            datapath -> sequencer
//   mem_req, mem_we, addr_sel, ir_load,
//   decoder_enable, reg_enable, reg_we,
//   alu_enable, pc_enable, halted, fault,
//   state[2:0]                              sequencer -> datapath
//   cycle_count, instret_count [CNT_W-1:0]  only when CTRL_PERF_CNT_EN is defined
interface control_sequencer_if
`ifdef CTRL_PERF_CNT_EN
    #(parameter int CNT_W = 32)
`endif
    ;
    logic       halt;
    logic       mem_ready;
    logic [6:0] opcode;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       decoder_enable;
    logic       reg_enable;
    logic       reg_we;
    logic       alu_enable;
    logic       pc_enable;
    logic       halted;
    logic       fault;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret_count;

    modport master (
        input  halt, mem_ready, opcode,
        output mem_req, mem_we, addr_sel, ir_load, decoder_enable, reg_enable,
               reg_we, alu_enable, pc_enable, halted, fault, state,
               cycle_count, instret_count
    );
    modport slave (
        output halt, mem_ready, opcode,
        input  mem_req, mem_we, addr_sel, ir_load, decoder_enable, reg_enable,
               reg_we, alu_enable, pc_enable, halted, fault, state,
               cycle_count, instret_count
    );
`else
    modport master (
        input  halt, mem_ready, opcode,
        output mem_req, mem_we, addr_sel, ir_load, decoder_enable, reg_enable,
               reg_we, alu_enable, pc_enable, halted, fault, state
    );
    modport slave (
        output halt, mem_ready, opcode,
        input  mem_req, mem_we, addr_sel, ir_load, decoder_enable, reg_enable,
               reg_we, alu_enable, pc_enable, halted, fault, state
    );
`endif
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Multi-cycle FSM sequencing the CPU datapath: FETCH/DECODE/EXECUTE/MEM/
//   WRITEBACK per instruction with a req/ready memory handshake, plus halt,
//   illegal-opcode and memory-timeout handling.
// Ports
//   clock  : system clock, all state changes on posedge
//   reset  : synchronous active-low reset
//   bus    : control_sequencer_if.master (halt/mem_ready/opcode in, unit
//            enables, address select, status and debug state out)
// Parameters
//   MEM_TIMEOUT : consecutive non-ready FETCH/MEM cycles before FAULT (0 = never)
//   CNT_W       : performance counter width
// Configuration
//   CTRL_PERF_CNT_EN : when defined, adds cycle_count / instret_count outputs.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                clock,
    input  logic                reset,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALTED    = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Counter just wide enough to hold MEM_TIMEOUT; 1 bit when timeout is off.
    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    if (CNT_W < 1 || MEM_TIMEOUT < 0) begin : g_param_chk
        $error("control_sequencer: CNT_W must be >= 1 and MEM_TIMEOUT >= 0");
    end

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_cnt;
    logic          waiting, tmo_hit, retire;
    logic          is_alu_op, is_load, is_store, is_legal;
    logic          mem_req, mem_we, addr_sel, ir_load, dec_en, reg_en, reg_we;
    logic          alu_en, pc_en, halted, fault;

    assign is_alu_op = (bus.opcode == OPC_OP) || (bus.opcode == OPC_IMM);
    assign is_load   = (bus.opcode == OPC_LOAD);
    assign is_store  = (bus.opcode == OPC_STORE);
    assign is_legal  = is_alu_op || is_load || is_store;

    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
    // Fires on the MEM_TIMEOUT-th consecutive non-ready cycle.
    assign tmo_hit = (MEM_TIMEOUT != 0) && waiting && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        dec_en   = 1'b0;
        reg_en   = 1'b0;
        reg_we   = 1'b0;
        alu_en   = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_IDLE: state_d = bus.halt ? S_HALTED : S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                dec_en  = 1'b1;
                reg_en  = 1'b1;
                state_d = is_legal ? S_EXECUTE : S_FAULT;
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                reg_en = 1'b1;
                if (is_alu_op)                 state_d = S_WRITEBACK;
                else if (is_load || is_store)  state_d = S_MEM;
                else                           state_d = S_FAULT;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                alu_en   = 1'b1;      // keeps the effective address on the bus
                if (bus.mem_ready) begin
                    if (is_store) retire  = 1'b1;
                    else          state_d = S_WRITEBACK;
                end else if (tmo_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                reg_en = 1'b1;
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (!bus.halt) state_d = S_FETCH;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
        // Halt is only honoured at an instruction boundary.
        if (retire) state_d = bus.halt ? S_HALTED : S_FETCH;
        pc_en = retire;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state_q <= state_d;
            // Any state change (including MEM -> FETCH on store retire) starts a fresh wait window.
            if (state_d != state_q)
                tmo_cnt <= '0;
            else if (waiting && (MEM_TIMEOUT != 0))
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.mem_req        = mem_req;
    assign bus.mem_we         = mem_we;
    assign bus.addr_sel       = addr_sel;
    assign bus.ir_load        = ir_load;
    assign bus.decoder_enable = dec_en;
    assign bus.reg_enable     = reg_en;
    assign bus.reg_we         = reg_we;
    assign bus.alu_enable     = alu_en;
    assign bus.pc_enable      = pc_en;
    assign bus.halted         = halted;
    assign bus.fault          = fault;
    assign bus.state          = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt, ret_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (state_q >= S_FETCH && state_q <= S_WRITEBACK) cyc_cnt <= cyc_cnt + 1'b1;
            if (pc_en)                                        ret_cnt <= ret_cnt + 1'b1;
        end
    end

    assign bus.cycle_count   = cyc_cnt;
    assign bus.instret_count = ret_cnt;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Builds an expected per-cycle trace for each instruction from its opcode,
//   memory wait counts and halt decision, then replays it against the DUT.
module tb_control_sequencer;
    localparam int TMO = 4;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    // Output bit positions in the expected vector (below the 3-bit state).
    localparam logic [10:0] O_REQ  = 11'h400;
    localparam logic [10:0] O_WE   = 11'h200;
    localparam logic [10:0] O_ASEL = 11'h100;
    localparam logic [10:0] O_IRL  = 11'h080;
    localparam logic [10:0] O_DEC  = 11'h040;
    localparam logic [10:0] O_REN  = 11'h020;
    localparam logic [10:0] O_RWE  = 11'h010;
    localparam logic [10:0] O_ALU  = 11'h008;
    localparam logic [10:0] O_PC   = 11'h004;
    localparam logic [10:0] O_HLT  = 11'h002;
    localparam logic [10:0] O_FLT  = 11'h001;

    typedef struct {
        logic        halt;
        logic        rdy;
        logic [6:0]  op;
        logic [13:0] exp;
    } cyc_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    cyc_t trace[$];
`ifdef CTRL_PERF_CNT_EN
    int unsigned m_cyc = 0;
    int unsigned m_ret = 0;
`endif

    always #5 clock = ~clock;

`ifdef CTRL_PERF_CNT_EN
    control_sequencer_if #(.CNT_W(32)) bus();
`else
    control_sequencer_if bus();
`endif

    control_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] obs();
        return {bus.state, bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load,
                bus.decoder_enable, bus.reg_enable, bus.reg_we, bus.alu_enable,
                bus.pc_enable, bus.halted, bus.fault};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic h, logic r, logic [6:0] op, logic [2:0] st, logic [10:0] o);
        cyc_t c;
        c.halt = h;
        c.rdy  = r;
        c.op   = op;
        c.exp  = {st, o};
        trace.push_back(c);
    endfunction

    function automatic void add_fault(int n);
        for (int i = 0; i < n; i++) push(rnd(), rnd(), 7'($urandom), 3'd7, O_FLT);
    endfunction

    // n cycles with halt held, then one cycle with halt released.
    function automatic void add_halted(int n);
        for (int i = 0; i < n; i++) push(1'b1, rnd(), 7'($urandom), 3'd6, O_HLT);
        push(1'b0, rnd(), 7'($urandom), 3'd6, O_HLT);
    endfunction

    // One instruction starting in FETCH. fw/mw = non-ready cycles before ready.
    function automatic void add_instr(logic [6:0] op, int fw, int mw, logic halt_ret);
        logic [6:0]  junk;
        logic        legal, mem, st;
        logic [10:0] mo;
        junk  = 7'($urandom);
        legal = (op == OP) || (op == OPIMM) || (op == LOAD) || (op == STORE);
        mem   = (op == LOAD) || (op == STORE);
        st    = (op == STORE);
        mo    = O_REQ | O_ASEL | O_ALU | (st ? O_WE : 11'h0);
        for (int i = 0; i < fw && i < TMO; i++) push(rnd(), 1'b0, junk, 3'd1, O_REQ);
        if (fw >= TMO) begin add_fault(6); return; end
        push(rnd(), 1'b1, junk, 3'd1, O_REQ | O_IRL);
        push(rnd(), rnd(), op, 3'd2, O_DEC | O_REN);
        if (!legal) begin add_fault(10); return; end
        push(rnd(), rnd(), op, 3'd3, O_ALU | O_REN);
        if (mem) begin
            for (int i = 0; i < mw && i < TMO; i++) push(rnd(), 1'b0, op, 3'd4, mo);
            if (mw >= TMO) begin add_fault(6); return; end
        end
        if (st) begin
            push(halt_ret, 1'b1, op, 3'd4, mo | O_PC);
        end else begin
            if (mem) push(rnd(), 1'b1, op, 3'd4, mo);
            push(halt_ret, rnd(), op, 3'd5, O_REN | O_RWE | O_PC);
        end
        if (halt_ret) add_halted($urandom_range(0, 3));
    endfunction

    task automatic play();
        cyc_t c;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            @(negedge clock);
            bus.halt      = c.halt;
            bus.mem_ready = c.rdy;
            bus.opcode    = c.op;
            #1;
            chk($sformatf("cyc%0d_st%0d", cyc_n, c.exp[13:11]), 64'(obs()), 64'(c.exp));
`ifdef CTRL_PERF_CNT_EN
            chk($sformatf("cyc%0d_cycle_count", cyc_n), 64'(bus.cycle_count), 64'(m_cyc));
            chk($sformatf("cyc%0d_instret", cyc_n), 64'(bus.instret_count), 64'(m_ret));
            if (c.exp[13:11] >= 3'd1 && c.exp[13:11] <= 3'd5) m_cyc++;
            if ((c.exp[10:0] & O_PC) != 11'h0) m_ret++;
`endif
            cyc_n++;
        end
    endtask

    // Holds reset for n edges, checks outputs are cleared, then releases with
    // halt_idle presented for the IDLE cycle that follows.
    task automatic do_reset(int n, logic halt_idle);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.halt      = rnd();
            bus.mem_ready = rnd();
            bus.opcode    = 7'($urandom);
            @(negedge clock);
            #1;
            chk($sformatf("rst%0d_outputs", cyc_n), 64'(obs()), 64'h0);
`ifdef CTRL_PERF_CNT_EN
            chk("rst_cycle_count", 64'(bus.cycle_count), 64'h0);
            chk("rst_instret", 64'(bus.instret_count), 64'h0);
`endif
        end
`ifdef CTRL_PERF_CNT_EN
        m_cyc = 0;
        m_ret = 0;
`endif
        reset    = 1'b1;
        bus.halt = halt_idle;
    endtask

    initial begin
        logic [6:0] ops[4];
        logic [6:0] bad;
        ops[0] = OP; ops[1] = OPIMM; ops[2] = LOAD; ops[3] = STORE;
        bus.halt = 1'b0; bus.mem_ready = 1'b1; bus.opcode = OP;

        // Basic OP flow, twice (also exercises the performance counters).
        do_reset(2, 1'b0);
        add_instr(OP, 0, 0, 1'b0);
        add_instr(OP, 0, 0, 1'b0);
        // LOAD with three MEM wait cycles, zero-wait STORE.
        add_instr(LOAD, 0, 3, 1'b0);
        add_instr(STORE, 0, 0, 1'b0);
        // Halt at retire of an ALU op, then resume.
        add_instr(OPIMM, 1, 0, 1'b1);
        play();

        // Randomized legal instruction stream.
        for (int i = 0; i < 25; i++)
            add_instr(ops[$urandom_range(0, 3)], $urandom_range(0, TMO - 1),
                      $urandom_range(0, TMO - 1), ($urandom_range(0, 4) == 0));
        add_instr(STORE, 0, 2, 1'b1);
        play();

        // Illegal opcode -> sticky fault; reset with halt in IDLE -> HALTED.
        add_instr(7'b1111111, 0, 0, 1'b0);
        play();
        do_reset(2, 1'b1);
        add_halted(2);
        add_instr(OP, 0, 0, 1'b0);
        do begin bad = 7'($urandom); end
        while (bad == OP || bad == OPIMM || bad == LOAD || bad == STORE);
        add_instr(bad, 2, 0, 1'b0);
        play();

        // Fetch timeout after exactly TMO non-ready cycles.
        do_reset(1, 1'b0);
        add_instr(LOAD, TMO, 0, 1'b0);
        play();
        // Memory-phase timeout.
        do_reset(1, 1'b0);
        add_instr(STORE, 0, TMO, 1'b0);
        play();

        // Reset asserted while a LOAD waits in MEM.
        do_reset(1, 1'b0);
        add_instr(LOAD, 0, 3, 1'b0);
        while (trace.size() > 4) void'(trace.pop_back());
        play();
        do_reset(1, 1'b0);
        add_instr(STORE, 2, 1, 1'b0);
        add_instr(LOAD, 1, 1, 1'b1);
        play();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
